// File: rtl/fetch_align_buffer.sv
// rtl/fetch_align_buffer.sv - realigns fetch words into RV32IMC instructions for decode
//
// Build option: define TCORE_ALIGN_PERF_EN to add split_stall_cnt_o.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i, redirect_pc_i redirect: empty the buffer and restart at redirect_pc_i
//   fetch_*                word-aligned 32-bit fetch words (valid/ready handshake)
//   dec_*                  one instruction per handshake with PC, compressed and fault flags
//   split_stall_cnt_o      (option) cycles spent waiting for the upper half of a split 32-bit instruction
module fetch_align_buffer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic            fetch_fault_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [31:0]     dec_inst_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic            dec_is_comp_o,
  output logic            dec_fault_o
`ifdef TCORE_ALIGN_PERF_EN
  ,
  output logic [31:0]     split_stall_cnt_o
`endif
);

  typedef enum logic {
    ST_RUN,
    ST_FAULT_HOLD
  } state_e;

  // Slot 0 is always the oldest halfword (the start of the next instruction).
  logic [2:0][15:0] hw_q, hw_d;
  logic [2:0]       flt_q, flt_d;
  logic [1:0]       count_q, count_d;
  state_e           state_q, state_d;
  logic             drop_half_q, drop_half_d;
  logic [XLEN-1:0]  pc_q, pc_d;

  logic       is_comp;
  logic       inst_fault;
  logic       run;
  logic       pop;
  logic       push;
  logic [1:0] pop_n;
  logic [1:0] push_n;
  logic [1:0] rem;

  always_comb begin
    run        = (state_q == ST_RUN);
    is_comp    = (hw_q[0][1:0] != 2'b11);
    // A 32-bit instruction is faulty if either of its halves is; a faulty slot 0
    // is presented even when its partner halfword can never arrive.
    inst_fault = flt_q[0] || (!is_comp && (count_q >= 2'd2) && flt_q[1]);

    fetch_ready_o = run && (count_q <= 2'd1);
    dec_valid_o   = run && (count_q != 2'd0) && (is_comp || (count_q >= 2'd2) || flt_q[0]);
    dec_fault_o   = dec_valid_o && inst_fault;
    dec_is_comp_o = dec_valid_o && !inst_fault && is_comp;
    dec_pc_o      = pc_q;
    dec_inst_o    = '0;
    if (dec_valid_o && !inst_fault) begin
      dec_inst_o = is_comp ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
    end

    pop    = dec_valid_o && dec_ready_i;
    push   = fetch_valid_i && fetch_ready_o;
    pop_n  = !pop ? 2'd0 : ((is_comp || (count_q < 2'd2)) ? 2'd1 : 2'd2);
    push_n = !push ? 2'd0 : (drop_half_q ? 2'd1 : 2'd2);
    rem    = count_q - pop_n;

    // Shift out the popped halfwords first, then append the fetch word behind
    // whatever remains. Pushes only happen with count<=1, so rem<=1 here.
    case (pop_n)
      2'd1: begin
        hw_d  = {16'h0000, hw_q[2:1]};
        flt_d = {1'b0, flt_q[2:1]};
      end
      2'd2: begin
        hw_d  = {32'h0000_0000, hw_q[2]};
        flt_d = {2'b00, flt_q[2]};
      end
      default: begin
        hw_d  = hw_q;
        flt_d = flt_q;
      end
    endcase

    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) == rem) begin
          hw_d[i]  = drop_half_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
          flt_d[i] = fetch_fault_i;
        end else if (!drop_half_q && (2'(i) == 2'(rem + 2'd1))) begin
          hw_d[i]  = fetch_data_i[31:16];
          flt_d[i] = fetch_fault_i;
        end
      end
    end

    count_d     = rem + push_n;
    drop_half_d = push ? 1'b0 : drop_half_q;
    pc_d        = pop ? (pc_q + (is_comp ? XLEN'(2) : XLEN'(4))) : pc_q;
    state_d     = (pop && inst_fault) ? ST_FAULT_HOLD : state_q;

    // Redirect wins over any same-cycle push or pop.
    if (flush_i) begin
      count_d     = 2'd0;
      state_d     = ST_RUN;
      pc_d        = redirect_pc_i;
      drop_half_d = redirect_pc_i[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_q        <= '0;
      flt_q       <= '0;
      count_q     <= 2'd0;
      state_q     <= ST_RUN;
      drop_half_q <= RESET_PC[1];
      pc_q        <= RESET_PC;
    end else begin
      hw_q        <= hw_d;
      flt_q       <= flt_d;
      count_q     <= count_d;
      state_q     <= state_d;
      drop_half_q <= drop_half_d;
      pc_q        <= pc_d;
    end
  end

`ifdef TCORE_ALIGN_PERF_EN
  logic [31:0] split_stall_cnt_q, split_stall_cnt_d;

  // Counts cycles stuck holding only the lower half of a 32-bit instruction.
  always_comb begin
    split_stall_cnt_d = split_stall_cnt_q;
    if (run && (count_q == 2'd1) && !is_comp && (split_stall_cnt_q != 32'hFFFF_FFFF)) begin
      split_stall_cnt_d = split_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      split_stall_cnt_q <= '0;
    end else begin
      split_stall_cnt_q <= split_stall_cnt_d;
    end
  end

  assign split_stall_cnt_o = split_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb/tb_fetch_align_buffer.sv - directed scoreboard bench for fetch_align_buffer
module tb_fetch_align_buffer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        fetch_fault_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_inst_o;
  logic [31:0] dec_pc_o;
  logic        dec_is_comp_o;
  logic        dec_fault_o;
`ifdef TCORE_ALIGN_PERF_EN
  logic [31:0] split_stall_cnt_o;
`endif

  fetch_align_buffer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_data_i  (fetch_data_i),
    .fetch_fault_i (fetch_fault_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_inst_o    (dec_inst_o),
    .dec_pc_o      (dec_pc_o),
    .dec_is_comp_o (dec_is_comp_o),
    .dec_fault_o   (dec_fault_o)
`ifdef TCORE_ALIGN_PERF_EN
    ,
    .split_stall_cnt_o (split_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] inst, input logic [31:0] pc,
                          input logic comp, input logic flt);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.comp = comp;
    e.flt  = flt;
    sb.push_back(e);
  endtask

  // Inputs change at posedge+1; a handshake seen at negedge completes at the next posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_ni && dec_valid_o && dec_ready_i) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("dec_inst", 64'(dec_inst_o), 64'(e.inst));
        chk("dec_pc", 64'(dec_pc_o), 64'(e.pc));
        chk("dec_is_comp", 64'(dec_is_comp_o), 64'(e.comp));
        chk("dec_fault", 64'(dec_fault_o), 64'(e.flt));
      end
    end
  end

  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = '0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    fetch_fault_i = 1'b0;
    dec_ready_i   = 1'b1;
    tick();
    tick();
    chk("rst_dec_valid", 64'(dec_valid_o), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready_o), 64'd1);
    chk("rst_dec_inst", 64'(dec_inst_o), 64'd0);
    chk("rst_dec_pc", 64'(dec_pc_o), 64'h8000_0000);
    rst_ni = 1'b1;
    tick();

    // aligned 32-bit instruction, one-cycle latency
    exp_push(32'h0000_0013, 32'h8000_0000, 1'b0, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0000_0013;
    tick();
    fetch_valid_i = 1'b0;
    chk("t1_valid_next", 64'(dec_valid_o), 64'd1);
    chk("t1_inst_next", 64'(dec_inst_o), 64'h0000_0013);
    tick();
    chk("t1_drained", 64'(dec_valid_o), 64'd0);

    // two compressed instructions in one word
    exp_push(32'h0000_4501, 32'h8000_0004, 1'b1, 1'b0);
    exp_push(32'h0000_4505, 32'h8000_0006, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h4505_4501;
    tick();
    fetch_valid_i = 1'b0;
    tick();
    tick();
    chk("t2_drained", 64'(dec_valid_o), 64'd0);

    // 32-bit instruction straddling two words
    exp_push(32'h0000_4501, 32'h8000_0008, 1'b1, 1'b0);
    exp_push(32'h0000_0013, 32'h8000_000A, 1'b0, 1'b0);
    exp_push(32'h0000_1234, 32'h8000_000E, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0013_4501;
    tick();
    fetch_valid_i = 1'b0;
    tick();
    chk("t3_wait_valid", 64'(dec_valid_o), 64'd0);
    chk("t3_wait_ready", 64'(fetch_ready_o), 64'd1);
    tick();
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h1234_0000;
    tick();
    fetch_valid_i = 1'b0;
    chk("t3_split_valid", 64'(dec_valid_o), 64'd1);
    chk("t3_full_ready", 64'(fetch_ready_o), 64'd0);
`ifdef TCORE_ALIGN_PERF_EN
    chk("t3_stall_cnt", 64'(split_stall_cnt_o), 64'd2);
`endif
    tick();
    tick();
    chk("t3_drained", 64'(dec_valid_o), 64'd0);

    // redirect to a misaligned target; concurrent fetch word is discarded
    flush_i       = 1'b1;
    redirect_pc_i = 32'h8000_0102;
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'hDEAD_BEEF;
    tick();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    chk("t4_flush_valid", 64'(dec_valid_o), 64'd0);
    chk("t4_flush_pc", 64'(dec_pc_o), 64'h8000_0102);
    exp_push(32'h0000_4505, 32'h8000_0102, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h4505_FFFF;
    tick();
    fetch_valid_i = 1'b0;
    tick();
    chk("t4_drained", 64'(dec_valid_o), 64'd0);

    // access fault, then hold until redirect
    exp_push(32'h0000_0000, 32'h8000_0104, 1'b0, 1'b1);
    fetch_valid_i = 1'b1;
    fetch_fault_i = 1'b1;
    fetch_data_i  = 32'h0000_0013;
    tick();
    fetch_valid_i = 1'b0;
    fetch_fault_i = 1'b0;
    chk("t5_fault_out", 64'(dec_fault_o), 64'd1);
    chk("t5_fault_inst", 64'(dec_inst_o), 64'd0);
    tick();
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h4505_4501;
    tick();
    tick();
    chk("t5_hold_ready", 64'(fetch_ready_o), 64'd0);
    chk("t5_hold_valid", 64'(dec_valid_o), 64'd0);
    flush_i       = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    tick();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    chk("t5_flush_ready", 64'(fetch_ready_o), 64'd1);
    chk("t5_flush_valid", 64'(dec_valid_o), 64'd0);

    // backpressure from decode, then mid-stream reset
    exp_push(32'h0000_4505, 32'h8000_0200, 1'b1, 1'b0);
    exp_push(32'h0000_4509, 32'h8000_0202, 1'b1, 1'b0);
    exp_push(32'h0000_450D, 32'h8000_0204, 1'b1, 1'b0);
    exp_push(32'h0000_4511, 32'h8000_0206, 1'b1, 1'b0);
    dec_ready_i   = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h4509_4505;
    tick();
    fetch_data_i  = 32'h4511_450D;
    chk("t6_bp_ready", 64'(fetch_ready_o), 64'd0);
    chk("t6_bp_valid", 64'(dec_valid_o), 64'd1);
    tick();
    tick();
    chk("t6_bp_hold_inst", 64'(dec_inst_o), 64'h0000_4505);
    chk("t6_bp_hold_ready", 64'(fetch_ready_o), 64'd0);
    dec_ready_i = 1'b1;
    tick();
    chk("t6_resume_ready", 64'(fetch_ready_o), 64'd1);
    tick();
    fetch_valid_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(dec_valid_o), 64'd0);
    chk("t6_rst_ready", 64'(fetch_ready_o), 64'd1);
    chk("t6_rst_inst", 64'(dec_inst_o), 64'd0);
    chk("t6_rst_comp", 64'(dec_is_comp_o), 64'd0);
    chk("t6_rst_fault", 64'(dec_fault_o), 64'd0);
    chk("t6_rst_pc", 64'(dec_pc_o), 64'h8000_0000);
    chk("t6_outstanding", 64'(sb.size()), 64'd1);
    sb.delete();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("final_idle", 64'(dec_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Producer side of the decode stage's instruction input.
- Accepts word-aligned 32-bit fetch words from the fetch/icache path and extracts RV32IMC instructions, which may be 16-bit or 32-bit and may straddle a word boundary.
- Presents one instruction at a time to decode with its PC, a compressed flag and a fetch-fault flag.
- Holds up to three halfword parcels; handles misaligned redirect targets.

Parameters:
- XLEN, 32, datapath / PC width.
- RESET_PC, 32'h8000_0000, dec_pc_o value after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline redirect; empties buffer
- redirect_pc_i  in  XLEN  new PC, sampled when flush_i=1
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  buffer can accept a word
- fetch_data_i  in  32  word-aligned fetch data, halfword 0 in [15:0]
- fetch_fault_i  in  1  instruction access fault for this word
- dec_valid_o  out  1  instruction available
- dec_ready_i  in  1  decode accepts instruction
- dec_inst_o  out  32  instruction; compressed instructions zero-extended in [31:16]
- dec_pc_o  out  XLEN  PC of dec_inst_o
- dec_is_comp_o  out  1  instruction is 16-bit
- dec_fault_o  out  1  instruction carries access fault

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - Reset is asynchronous, active-low on rst_ni.
  - Reset values: count=0, state=RUN, drop_half=RESET_PC[1], pc=RESET_PC.
  - Outputs during reset: dec_valid_o=0, fetch_ready_o=1, dec_inst_o=0, dec_is_comp_o=0, dec_fault_o=0.
- Storage: 3 halfword slots (48 bits) plus a per-slot fault bit; count 0..3 halfwords.
- fetch_ready_o:
  - Equals (count<=1) && state==RUN.
  - Depends on registered state only; no combinational path from dec_ready_i.
- Push (fetch_valid_i && fetch_ready_o):
  - Appends both halfwords, or only the upper halfword if drop_half=1; drop_half then clears.
- Instruction format:
  - Slot0[1:0]!=2'b11 means compressed; needs 1 halfword.
  - Otherwise needs 2 halfwords.
- dec_valid_o:
  - Asserted when count >= needed halfwords, or when slot0 is faulty (count>=1).
  - Combinational from registered buffer only.
- Pop (dec_valid_o && dec_ready_i):
  - Removes 1 or 2 halfwords and shifts the remaining slots down.
  - pc += 2 (compressed) or 4.
- Simultaneous push and pop in the same cycle:
  - count_next = count - popped + pushed.
  - Pushed data lands after the remaining slots.
- Latency: word accepted in cycle N gives dec_valid_o in cycle N+1, provided it completes an instruction.
- Fault handling:
  - When the output instruction includes a faulty halfword: dec_fault_o=1, dec_inst_o=0, dec_is_comp_o=0.
  - Pop of a faulty instruction moves state RUN->FAULT_HOLD.
  - FAULT_HOLD: dec_valid_o=0, fetch_ready_o=0 until flush_i.
- flush_i (highest priority, overrides push/pop in the same cycle):
  - Next cycle: count=0, state=RUN, pc=redirect_pc_i, drop_half=redirect_pc_i[1].
  - Concurrent fetch word is discarded.
  - dec_valid_o is 0 in the cycle after flush.
  - Upstream guarantees no pre-flush words arrive after flush_i.
- Wrap-around: PC increment wraps modulo 2^XLEN; no special handling.
- Invariant: count never exceeds 3; pushes only when count<=1.

Optional Feature:
- Macro: TCORE_ALIGN_PERF_EN.
- Defined:
  - Adds output split_stall_cnt_o (32 bits), reset 0.
  - Increments each cycle where count==1, slot0 is a non-compressed lower half and state==RUN.
  - Saturates at 32'hFFFF_FFFF; cleared by reset only, not by flush.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset then push 32'h0000_0013 (addi, aligned), dec_ready_i=1 -> next cycle dec_valid_o=1, dec_inst_o=32'h0000_0013, dec_pc_o=32'h8000_0000, dec_is_comp_o=0.
- Push 32'h4505_4501 (two c.li) -> two consecutive instructions 32'h0000_4501 @8000_0000 and 32'h0000_4505 @8000_0002, both dec_is_comp_o=1, then dec_valid_o=0.
- Push 32'h0013_4501 then 32'h1234_0000 -> first 32'h0000_4501 @8000_0000; then 32'h0000_0013, formed from halfwords {0000,0013}, @8000_0002 after the second word arrives; split_stall_cnt_o increments for each waiting cycle when enabled.
- flush_i with redirect_pc_i=32'h8000_0102, then push 32'h4505_FFFF -> lower half dropped; output 32'h0000_4505 @8000_0102.
- Push word with fetch_fault_i=1 -> dec_fault_o=1, dec_inst_o=0; after pop, fetch_ready_o=0 and dec_valid_o=0 until flush_i.
- dec_ready_i=0 while pushing 2 words of 16-bit instructions -> fetch_ready_o=0 once count reaches 2, no data lost; assert rst_ni low mid-stream -> all outputs return to reset values immediately.
